// File: rtl/add_accum_core.sv
// Registered unsigned add/sub/accumulate/load unit with valid/ready on both sides,
// optional saturation, per-result carry/borrow, sticky overflow and accumulate counter.
module add_accum_core #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             ovf_sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [1:0] M_ADD  = 2'b00;
  localparam logic [1:0] M_SUB  = 2'b01;
  localparam logic [1:0] M_ACC  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
  } rsp_t;

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   r;
  rsp_t             rsp;
  logic             accept;

  assign in_ready = ena && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    r         = '0;
    rsp.carry = 1'b0;
    case (in_mode)
      M_ADD: begin
        r         = {1'b0, in_a} + {1'b0, in_b};
        rsp.carry = r[WIDTH];
      end
      M_SUB: begin
        r         = {1'b0, in_a} - {1'b0, in_b};
        rsp.carry = (in_a < in_b);
      end
      M_ACC: begin
        r         = {1'b0, acc} + {1'b0, in_a};
        rsp.carry = r[WIDTH];
      end
      default: begin
        r         = {1'b0, in_a};
        rsp.carry = 1'b0;
      end
    endcase
    rsp.data = r[WIDTH-1:0];
    // Underflow only comes from SUB, so it clamps low; every other carry clamps high.
    if (SATURATE && rsp.carry)
      rsp.data = (in_mode == M_SUB) ? '0 : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_carry  <= 1'b0;
      ovf_sticky <= 1'b0;
      acc_count  <= '0;
      acc        <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= rsp.data;
        out_carry <= rsp.carry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && rsp.carry)
        ovf_sticky <= 1'b1;
      else if (sticky_clr)
        ovf_sticky <= 1'b0;

      if (accept && in_mode == M_ACC) begin
        acc <= rsp.data;
        if (acc_count != '1)
          acc_count <= acc_count + 1'b1;
      end else if (accept && in_mode == M_LOAD) begin
        acc       <= rsp.data;
        acc_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add_accum_core.sv
// Bench for add_accum_core: a saturating and a wrapping instance share stimulus and are
// checked every cycle against an integer model, plus hand-computed directed expectations.
module tb_add_accum_core;

  localparam int W = 8;
  localparam int CW = 4;
  localparam int MAXV = 255;
  localparam int MAXC = 15;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1, in_valid = 1'b0, out_ready = 1'b1, sticky_clr = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [1:0] in_mode = ADD;

  logic [1:0] in_ready, out_valid, out_carry, ovf_sticky;
  logic [W-1:0] out_data [2];
  logic [CW-1:0] acc_count [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // index 1 saturates, index 0 wraps
  add_accum_core #(.WIDTH(W), .CNT_W(CW), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_data(out_data[1]), .out_carry(out_carry[1]),
    .ovf_sticky(ovf_sticky[1]), .sticky_clr(sticky_clr), .acc_count(acc_count[1]));

  add_accum_core #(.WIDTH(W), .CNT_W(CW), .SATURATE(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data[0]), .out_carry(out_carry[0]),
    .ovf_sticky(ovf_sticky[0]), .sticky_clr(sticky_clr), .acc_count(acc_count[0]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_acc [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_data[2] = '{0, 0};
  bit m_vld [2] = '{0, 0};
  bit m_cy  [2] = '{0, 0};
  bit m_stk [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    int s, res;
    bit c, rdy, sat;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_data[k] = 0;
        m_vld[k] = 0; m_cy[k] = 0; m_stk[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        sat = (k == 1);
        rdy = ena && (!m_vld[k] || out_ready);
        c = 0;
        if (in_valid && rdy) begin
          case (in_mode)
            ADD: begin
              s = int'(in_a) + int'(in_b);
              c = s > MAXV;
              res = c ? (sat ? MAXV : s - (MAXV + 1)) : s;
            end
            SUB: begin
              c = in_a < in_b;
              s = int'(in_a) - int'(in_b);
              res = c ? (sat ? 0 : s + MAXV + 1) : s;
            end
            ACC: begin
              s = m_acc[k] + int'(in_a);
              c = s > MAXV;
              res = c ? (sat ? MAXV : s - (MAXV + 1)) : s;
              m_acc[k] = res;
              m_cnt[k] = (m_cnt[k] < MAXC) ? m_cnt[k] + 1 : MAXC;
            end
            default: begin
              res = int'(in_a);
              m_acc[k] = res;
              m_cnt[k] = 0;
            end
          endcase
          m_vld[k] = 1; m_data[k] = res; m_cy[k] = c;
        end else if (out_ready) begin
          m_vld[k] = 0;
        end
        if (in_valid && rdy && c) m_stk[k] = 1;
        else if (sticky_clr) m_stk[k] = 0;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_ready[%0d]", k), in_ready[k], ena && (!m_vld[k] || out_ready));
        chk($sformatf("out_valid[%0d]", k), out_valid[k], m_vld[k]);
        if (m_vld[k]) begin
          chk($sformatf("out_data[%0d]", k), out_data[k], m_data[k]);
          chk($sformatf("out_carry[%0d]", k), out_carry[k], m_cy[k]);
        end
        chk($sformatf("ovf_sticky[%0d]", k), ovf_sticky[k], m_stk[k]);
        chk($sformatf("acc_count[%0d]", k), acc_count[k], m_cnt[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic beat(input logic [1:0] m, input int a, input int b);
    in_valid = 1'b1; in_mode = m; in_a = W'(a); in_b = W'(b);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset out_valid", out_valid[1], 0);
    chk("reset out_data", out_data[1], 0);
    chk("reset acc_count", acc_count[1], 0);
    chk("reset ovf_sticky", ovf_sticky[0], 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: ADD overflow
    beat(ADD, 200, 100);
    chk("add sat data", out_data[1], 255);
    chk("add wrap data", out_data[0], 44);
    chk("add carry", out_carry[1], 1);
    chk("add sticky", ovf_sticky[1], 1);

    // 2: SUB borrow / no borrow
    beat(SUB, 5, 9);
    chk("sub sat data", out_data[1], 0);
    chk("sub wrap data", out_data[0], 252);
    chk("sub borrow", out_carry[0], 1);
    beat(SUB, 9, 5);
    chk("sub 9-5 data", out_data[1], 4);
    chk("sub 9-5 carry", out_carry[1], 0);

    // 3: LOAD / ACC back-to-back, then count saturation
    beat(LOAD, 10, 77);
    chk("load data", out_data[1], 10);
    beat(ACC, 20, 0);
    chk("acc1 data", out_data[1], 30);
    beat(ACC, 30, 0);
    chk("acc2 data", out_data[0], 60);
    chk("acc count 2", acc_count[1], 2);
    for (int i = 0; i < 20; i++) beat(ACC, 0, 0);
    chk("acc count sat", acc_count[1], 15);
    chk("acc count sat wrapinst", acc_count[0], 15);

    // 4: backpressure
    step();
    out_ready = 1'b0;
    beat(ADD, 1, 2);
    in_valid = 1'b1; in_mode = ADD; in_a = 8'd3; in_b = 8'd4;
    step();
    chk("bp held data", out_data[1], 3);
    chk("bp in_ready", in_ready[1], 0);
    out_ready = 1'b1;
    #1 chk("bp in_ready comb", in_ready[1], 1);
    #1 step();
    in_valid = 1'b0;
    chk("bp second data", out_data[1], 7);
    chk("bp second valid", out_valid[1], 1);

    // 5: sticky set wins over clear
    step();
    sticky_clr = 1'b1;
    beat(ADD, 255, 1);
    chk("sticky set wins", ovf_sticky[1], 1);
    chk("255+1 sat", out_data[1], 255);
    chk("255+1 wrap", out_data[0], 0);
    step();
    chk("sticky cleared", ovf_sticky[1], 0);
    sticky_clr = 1'b0;

    // 6: async reset mid-stream, then ena gating
    out_ready = 1'b0;
    beat(ADD, 1, 1);
    chk("pre-reset valid", out_valid[1], 1);
    rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid[1], 0);
    chk("async rst count", acc_count[1], 0);
    chk("async rst count wrapinst", acc_count[0], 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    beat(ACC, 5, 0);
    chk("post-reset acc", out_data[1], 5);
    chk("post-reset count", acc_count[1], 1);
    ena = 1'b0;
    in_valid = 1'b1; in_mode = ADD; in_a = 8'd9; in_b = 8'd9;
    #1 chk("ena0 in_ready", in_ready[1], 0);
    #1 step();
    step();
    chk("ena0 no result", out_valid[1], 0);
    in_valid = 1'b0;
    ena = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
